// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Purpose : Bundles the fetch stage's two handshakes and the redirect input:
//           the req/ready channel to instruction memory, the valid/ready
//           channel to decode, and the branch redirect from execute.
// Modports:
//   master - the fetch unit side (drives imem_req/imem_addr and the
//            instruction register outputs, receives memory data, decode
//            ready and branch redirects)
//   slave  - the environment side (memory + decode + execute)
// Signals :
//   imem_req, imem_addr              fetch request and address
//   imem_rdata, imem_ready           memory data and accept strobe
//   instr_valid, instr_out, instr_pc instruction register towards decode
//   instr_ready                      decode consumes the held instruction
//   branch_taken, branch_target      single-cycle redirect from execute
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int INSTR_WIDTH = 16
);
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   imem_ready;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   branch_taken;
    logic [ADDR_WIDTH-1:0]  branch_target;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ready,
        output instr_valid, instr_out, instr_pc,
        input  instr_ready,
        input  branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ready,
        input  instr_valid, instr_out, instr_pc,
        output instr_ready,
        output branch_taken, branch_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Purpose : Fetch stage of the 16-bit processor. Owns the program counter,
//           requests instructions from instruction memory with a req/ready
//           handshake, holds the fetched word in an instruction register and
//           offers it to decode with a valid/ready handshake. Taken branches
//           redirect the PC; a branch arriving while a memory request is
//           still outstanding is remembered and applied once memory answers.
// Ports   :
//   i_clk           rising-edge clock
//   i_rst           synchronous reset, active-high
//   bus (master)    memory, decode and redirect signals (instr_fetch_unit_if)
//   o_stall_cycles  16-bit saturating count of cycles with imem_req=1 and
//                   imem_ready=0; present only when FETCH_STALL_CNT_EN is
//                   defined
// Parameters:
//   ADDR_WIDTH   PC width, PC wraps modulo 2**ADDR_WIDTH
//   INSTR_WIDTH  instruction word width
//   RESET_PC     PC value loaded on reset
// Configuration:
//   FETCH_STALL_CNT_EN  define to add the stall counter and its port
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    instr_fetch_unit_if.master        bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]               o_stall_cycles
`endif
);

    // FETCH : request outstanding at the PC
    // FLUSH : request outstanding at the old PC, its data will be dropped
    // VALID : instruction register full, waiting for decode
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FLUSH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [ADDR_WIDTH-1:0]   r_target;
    logic [INSTR_WIDTH-1:0]  r_instr;
    logic [ADDR_WIDTH-1:0]   r_instr_pc;
    logic                    r_instr_valid;

    logic [ADDR_WIDTH-1:0]   w_pc_inc;
    logic                    w_req;

    // Shared incrementer; natural overflow gives the wrap to zero.
    assign w_pc_inc = r_pc + ADDR_WIDTH'(1);

    // The request is combinational so it is already up in the first cycle
    // after reset; the address is the PC, which only moves when the
    // request is either accepted or not being made.
    assign w_req             = (r_state != S_VALID);
    assign bus.imem_req      = w_req;
    assign bus.imem_addr     = r_pc;
    assign bus.instr_valid   = r_instr_valid;
    assign bus.instr_out     = r_instr;
    assign bus.instr_pc      = r_instr_pc;

    // Fetch sequencer. Branches take priority over both handshakes. A branch
    // that cannot be applied immediately (memory has not answered) is parked
    // in r_target so the address stays stable until the request completes;
    // a later branch during that wait simply overwrites the parked target.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_target      <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (bus.branch_taken) begin
                        if (bus.imem_ready) begin
                            r_pc <= bus.branch_target;
                        end else begin
                            r_target <= bus.branch_target;
                            r_state  <= S_FLUSH;
                        end
                    end else if (bus.imem_ready) begin
                        r_instr       <= bus.imem_rdata;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_VALID;
                    end
                end

                S_FLUSH: begin
                    // The newest branch wins, even in the cycle memory answers.
                    if (bus.branch_taken) begin
                        r_target <= bus.branch_target;
                    end
                    if (bus.imem_ready) begin
                        r_pc    <= bus.branch_taken ? bus.branch_target : r_target;
                        r_state <= S_FETCH;
                    end
                end

                S_VALID: begin
                    if (bus.branch_taken) begin
                        r_pc          <= bus.branch_target;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end else if (bus.instr_ready) begin
                        r_pc          <= w_pc_inc;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end

                default: begin
                    r_state       <= S_FETCH;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Counts memory wait cycles and sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_req && !bus.imem_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cycles = r_stall_cnt;
`endif

endmodule
